// File: rtl/demux_dist.sv
// demux_dist: registered 1-to-LANES distributor with per-lane valid/ready
// holding registers, lane occupancy count and illegal-select drop counter.
module demux_dist #(
    parameter int WIDTH = 2,
    parameter int LANES = 31,
    parameter int SELW  = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [SELW-1:0]        in_sel,
    input  logic [WIDTH-1:0]       in_data,
    output logic [LANES-1:0]       out_valid,
    input  logic [LANES-1:0]       out_ready,
    output logic [LANES*WIDTH-1:0] out_data,
    output logic [SELW-1:0]        lane_cnt,
    output logic [7:0]             drop_cnt,
    output logic                   err,
    input  logic                   err_clr
);

    logic [LANES-1:0] sel_oh;
    logic [LANES-1:0] load;
    logic [LANES-1:0] drain;
    logic [LANES-1:0] freed;
    logic             legal;
    logic             acc;
    logic             drop_acc;
    logic             inc;
    logic [SELW-1:0]  dec;

    // One-hot lane decode; an out-of-range select decodes to all zeros.
    always_comb begin
        sel_oh = '0;
        for (int i = 0; i < LANES; i++) begin
            sel_oh[i] = (in_sel == SELW'(i));
        end
    end

    assign legal    = |sel_oh;
    assign in_ready = !legal || |(sel_oh & (~out_valid | out_ready));
    assign acc      = in_valid && in_ready;
    assign load     = acc ? sel_oh : '0;
    assign drain    = out_valid & out_ready;
    assign freed    = drain & ~load;
    assign inc      = |(load & ~drain);
    assign drop_acc = acc && !legal;

    always_comb begin
        dec = '0;
        for (int i = 0; i < LANES; i++) begin
            dec = dec + SELW'(freed[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= '0;
            out_data  <= '0;
            lane_cnt  <= '0;
        end else begin
            out_valid <= (out_valid & ~drain) | load;
            lane_cnt  <= lane_cnt + SELW'(inc) - dec;
            for (int i = 0; i < LANES; i++) begin
                if (load[i]) begin
                    out_data[i*WIDTH +: WIDTH] <= in_data;
                end
            end
        end
    end

    // A clear in the same cycle as a drop yields a count of one.
    always_ff @(posedge clk) begin
        if (reset) begin
            drop_cnt <= '0;
            err      <= 1'b0;
        end else if (err_clr) begin
            drop_cnt <= drop_acc ? 8'd1 : 8'd0;
            err      <= drop_acc;
        end else if (drop_acc) begin
            if (drop_cnt != 8'hFF) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
            err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_demux_dist.sv
// Directed bench for demux_dist with a lane-data scoreboard and a
// reference model of occupancy, drop counter and error flag.
module tb_demux_dist;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_sel;
    logic [1:0]  in_data;
    logic [30:0] out_valid;
    logic [30:0] out_ready;
    logic [61:0] out_data;
    logic [4:0]  lane_cnt;
    logic [7:0]  drop_cnt;
    logic        err;
    logic        err_clr;

    demux_dist dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_sel   (in_sel),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .lane_cnt (lane_cnt),
        .drop_cnt (drop_cnt),
        .err      (err),
        .err_clr  (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         lane;
        logic [1:0] data;
    } sb_t;

    sb_t         sbq[$];
    int          tests = 0;
    int          fails = 0;
    logic [30:0] mv;
    logic [61:0] md;
    int          mcnt;
    int          mdrop;
    logic        merr;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle(input bit v, input int s, input logic [1:0] d,
                         input logic [30:0] r, input bit clr,
                         input bit rst);
        bit         legal;
        bit         rdy;
        bit         acc;
        logic [4:0] sl;
        int         k;
        sl        = 5'(s);
        in_valid  = v;
        in_sel    = sl;
        in_data   = d;
        out_ready = r;
        err_clr   = clr;
        reset     = rst;
        #1;
        legal = (s < 31);
        rdy   = !legal || !mv[s] || r[s];
        acc   = v && rdy;
        chk("in_ready", 64'(in_ready), 64'(rdy));
        if (!rst) begin
            for (int i = 0; i < 31; i++) begin
                if (mv[i] && r[i]) begin
                    k = -1;
                    for (int j = 0; j < sbq.size(); j++) begin
                        if (k < 0 && sbq[j].lane == i) k = j;
                    end
                    chk("sb_hit", 64'(k >= 0), 64'd1);
                    if (k >= 0) begin
                        chk("sb_data", 64'(out_data[i*2 +: 2]),
                            64'(sbq[k].data));
                        sbq.delete(k);
                    end
                end
            end
        end
        if (rst) begin
            mv = '0;
            md = '0;
            mdrop = 0;
            merr = 1'b0;
            sbq.delete();
        end else begin
            mv = mv & ~r;
            if (acc && legal) begin
                mv[s] = 1'b1;
                md[s*2 +: 2] = d;
                sbq.push_back('{lane: s, data: d});
            end
            if (clr) begin
                mdrop = (acc && !legal) ? 1 : 0;
                merr  = acc && !legal;
            end else if (acc && !legal) begin
                mdrop = (mdrop == 255) ? 255 : mdrop + 1;
                merr  = 1'b1;
            end
        end
        mcnt = $countones(mv);
        @(posedge clk);
        #1;
        chk("out_valid", 64'(out_valid), 64'(mv));
        chk("out_data", 64'(out_data), 64'(md));
        chk("lane_cnt", 64'(lane_cnt), 64'(mcnt));
        chk("drop_cnt", 64'(drop_cnt), 64'(mdrop));
        chk("err", 64'(err), 64'(merr));
    endtask

    initial begin
        mv = '0; md = '0; mcnt = 0; mdrop = 0; merr = 1'b0;
        in_valid = 0; in_sel = 0; in_data = 0;
        out_ready = '0; err_clr = 0; reset = 1;

        // reset
        cycle(0, 0, 2'd0, '0, 0, 1);
        cycle(0, 0, 2'd0, '0, 0, 1);
        chk("rst_valid", 64'(out_valid), 64'd0);

        // fill every lane with data = sel[1:0]
        for (int s = 0; s < 31; s++) begin
            cycle(1, s, 2'(s), '0, 0, 0);
        end
        chk("full_valid", 64'(out_valid), 64'h7FFF_FFFF);
        chk("full_cnt", 64'(lane_cnt), 64'd31);
        chk("lane5", 64'(out_data[11:10]), 64'd1);

        // blocked lane 7, then pass-through reload
        cycle(1, 7, 2'd3, '0, 0, 0);
        chk("lane7_hold", 64'(out_data[15:14]), 64'd3);
        cycle(1, 7, 2'd2, 31'(1 << 7), 0, 0);
        chk("lane7_reload", 64'(out_data[15:14]), 64'd2);
        chk("reload_cnt", 64'(lane_cnt), 64'd31);

        // illegal selects: saturate the drop counter
        for (int n = 0; n < 300; n++) begin
            cycle(1, 31, 2'(n), '0, 0, 0);
        end
        chk("drop_sat", 64'(drop_cnt), 64'd255);
        chk("err_set", 64'(err), 64'd1);

        // clear with simultaneous drop, then clear alone
        cycle(1, 31, 2'd0, '0, 1, 0);
        chk("clr_drop", 64'(drop_cnt), 64'd1);
        cycle(0, 31, 2'd0, '0, 1, 0);
        chk("clr_only", 64'(drop_cnt), 64'd0);

        // drain everything; ready on empty lanes is ignored
        cycle(0, 0, 2'd0, '1, 0, 0);
        cycle(0, 0, 2'd0, '1, 0, 0);
        chk("empty_cnt", 64'(lane_cnt), 64'd0);

        // three lanes drain while lane 15 loads
        cycle(1, 0, 2'd1, '0, 0, 0);
        cycle(1, 10, 2'd2, '0, 0, 0);
        cycle(1, 30, 2'd3, '0, 0, 0);
        chk("three_cnt", 64'(lane_cnt), 64'd3);
        cycle(1, 15, 2'd2, 31'h4000_0401, 0, 0);
        chk("multi_cnt", 64'(lane_cnt), 64'd1);
        chk("multi_valid", 64'(out_valid), 64'(1 << 15));

        // reset mid-stream with an item presented
        cycle(1, 3, 2'd1, '0, 0, 0);
        cycle(1, 31, 2'd0, '0, 0, 0);
        cycle(1, 4, 2'd3, '0, 0, 1);
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_data", 64'(out_data), 64'd0);
        chk("mid_rst_err", 64'(err), 64'd0);
        cycle(0, 4, 2'd0, '0, 0, 0);
        chk("post_rst_cnt", 64'(lane_cnt), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
